fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  - Sequences the program counter that addresses instruction_memory (combinational read, 9-bit words, 12-bit index).
//  - Starts a program on a start pulse and advances the PC each cycle: increment, branch redirect or stall hold.
//  - Stops on a decoded halt instruction or an out-of-range fetch, and reports done/fault to the top-level harness.
// PARAMETERS
//  PC_W        32    width of current_pc / branch_target
//  IMEM_DEPTH  4096  number of valid instruction words; legal PC range 0..IMEM_DEPTH-1
//  START_ADDR  0     PC loaded on reset and on every start
// PORTS
//  clk            in   1     single clock, all state updates on rising edge
//  reset          in   1     synchronous, active-low reset
//  start          in   1     1-cycle pulse: begin program at START_ADDR (honoured in IDLE/HALTED/FAULT)
//  stall          in   1     datapath not ready: hold PC, current instruction not retired
//  halt           in   1     decoder flags current instruction as program end
//  branch_taken   in   1     redirect PC to branch_target
//  branch_target  in   PC_W  absolute next PC when branch_taken
//  current_pc     out  PC_W  address to instruction_memory
//  fetch_valid    out  1     instruction at current_pc is live (RUN only)
//  done           out  1     program halted normally (level, held until start/reset)
//  fault          out  1     fetch target >= IMEM_DEPTH (level, held until start/reset)
//  retired_cnt    out  32    [FETCH_PERF_CNT_EN only] instructions retired
//  stall_cnt      out  32    [FETCH_PERF_CNT_EN only] cycles stalled in RUN
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE, current_pc=START_ADDR, fetch_valid=0, done=0, fault=0, counters=0.
//    Reset mid-program takes effect at that edge; no partial retire.
//  - States: IDLE, RUN, HALTED, FAULT. fetch_valid=1 only in RUN; done=1 only in HALTED; fault=1 only in FAULT.
//  - IDLE: start -> RUN, current_pc=START_ADDR. First instruction is valid the cycle after start is sampled.
//  - RUN, per edge, priority stall > halt > branch_taken > increment:
//    - stall: PC held, state held; halt/branch ignored that cycle.
//    - halt: -> HALTED, PC held at the halt instruction.
//    - branch_taken: next=branch_target.
//    - else: next=current_pc+1 (PC_W-bit add).
//    - If next >= IMEM_DEPTH (unsigned compare): -> FAULT, PC held at the offending source instruction.
//    - start while in RUN is ignored.
//  - HALTED/FAULT: PC held; start -> RUN at START_ADDR; done/fault clear on the same edge.
//  - Retire: a RUN cycle with stall==0 (includes the halt instruction and a faulting instruction).
//  - Zero-cycle latency from current_pc to instruction (the memory is combinational); no registered output stage.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined: retired_cnt/stall_cnt ports exist.
//    - Both counters clear on reset and on accepted start, and saturate at 32'hFFFF_FFFF.
//    - retired_cnt +1 per retire; stall_cnt +1 per RUN cycle with stall==1.
//  - Undefined: the counter ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - fetch_pkg: typedef enum logic [1:0] fetch_state_t {IDLE,RUN,HALTED,FAULT}; localparam PC_W default; PC_ONE constant.
//  - One sub-module, fetch_perf_counter (saturating 32-bit counter with clear/inc), instantiated twice under the macro.
//  - Next-PC mux and FSM stay in fetch_sequencer.
// TESTING
//  1. Release reset, pulse start, no stall/branch for 5 cycles
//     -> PC 0,1,2,3,4; fetch_valid=1 from the cycle after start.
//  2. At PC=3 assert branch_taken, target=0x20 -> next PC=0x20; assert stall 2 cycles -> PC holds 0x20 for those 2 cycles.
//  3. halt at PC=7 with stall=1 -> stays RUN at 7; drop stall -> HALTED next cycle, done=1, PC=7, fetch_valid=0.
//     Then pulse start -> PC=0, done=0.
//  4. Branch to 0xFFF (PC=0xFFF), then increment -> FAULT, fault=1, PC=0xFFF.
//     Also: branch_target=0x1000 -> FAULT immediately.
//  5. Drive reset=0 mid-RUN at PC=5 -> next edge IDLE, PC=0, all flags 0; start during RUN is ignored (PC continues).
//  6. FETCH_PERF_CNT_EN: 10 retires + 3 stalls then halt -> retired_cnt=11 (halt included), stall_cnt=3.
//     Preload 32'hFFFF_FFFF via force -> counter saturates.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  // Default program counter width
  localparam int DEFAULT_PC_W = 32;

  // Sequential-fetch increment
  localparam logic [31:0] PC_ONE = 32'd1;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  // Clear, otherwise count events until the counter is full
  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer for a combinational-read instruction memory.
// Optional build macro FETCH_PERF_CNT_EN adds retired/stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W       = DEFAULT_PC_W,
  parameter int IMEM_DEPTH = 4096,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] current_pc,
  output logic            fetch_valid,
  output logic            done,
  output logic            fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_INC   = PC_W'(PC_ONE);

  fetch_state_t    state_reg;
  logic [PC_W-1:0] pc_reg;
  logic            valid_reg;
  logic            done_reg;
  logic            fault_reg;

  logic [PC_W-1:0] pc_next;
  logic            pc_next_oob;
  logic            start_accept;

  // Next-PC selection: branch redirect or sequential increment, plus range check
  always_comb begin
    pc_next     = pc_reg + PC_INC;
    if (branch_taken) begin
      pc_next = branch_target;
    end
    pc_next_oob = (pc_next >= PC_LIMIT);
  end

  // Start is only honoured outside RUN
  assign start_accept = start && (state_reg != RUN);

  // Control FSM with registered PC and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= PC_START;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALTED, FAULT: begin
          if (start) begin
            state_reg <= RUN;
            pc_reg    <= PC_START;
            valid_reg <= 1'b1;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
          end
        end
        RUN: begin
          // A stalled cycle holds everything; halt/branch wait for it to clear
          if (!stall) begin
            if (halt) begin
              state_reg <= HALTED;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else if (pc_next_oob) begin
              // PC stays on the instruction that tried to leave memory
              state_reg <= FAULT;
              valid_reg <= 1'b0;
              fault_reg <= 1'b1;
            end else begin
              pc_reg <= pc_next;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
          fault_reg <= 1'b0;
        end
      endcase
    end
  end

  assign current_pc  = pc_reg;
  assign fetch_valid = valid_reg;
  assign done        = done_reg;
  assign fault       = fault_reg;

`ifdef FETCH_PERF_CNT_EN
  logic cnt_clear;
  logic retire_evt;
  logic stall_evt;

  assign cnt_clear  = !reset || start_accept;
  assign retire_evt = (state_reg == RUN) && !stall;
  assign stall_evt  = (state_reg == RUN) && stall;

  fetch_perf_counter u_retired_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (retire_evt),
    .count (retired_cnt)
  );

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (stall_evt),
    .count (stall_cnt)
  );
`else
  // Without counters the accepted-start decode has no consumer
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with hand-computed expectations.
// Counter checks are compiled when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            stall;
  logic            halt;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] current_pc;
  logic            fetch_valid;
  logic            done;
  logic            fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     retired_cnt;
  logic [31:0]     stall_cnt;
`endif

  int err_cnt   = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W       (PC_W),
    .IMEM_DEPTH (4096),
    .START_ADDR (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .current_pc    (current_pc),
    .fetch_valid   (fetch_valid),
    .done          (done),
    .fault         (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [31:0] pc,
                              input logic v, input logic d, input logic f);
    check({tag, ".pc"}, current_pc, pc);
    check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    check({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_target = '0;

    // Reset state
    tick(); tick();
    check_status("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_status("idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // 1. Sequential fetch 0..4 after start
    start = 1'b1; tick(); start = 1'b0;
    check_status("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("seq_pc%0d", i), current_pc, 32'(i));
    end
    halt = 1'b1; tick(); halt = 1'b0;
    check_status("halt4", 32'h4, 1'b0, 1'b1, 1'b0);

    // 2. Branch at PC=3 to 0x20, then two stall cycles
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("pc3", current_pc, 32'h3);
    branch_taken = 1'b1; branch_target = 32'h20; tick(); branch_taken = 1'b0;
    check("branch_pc", current_pc, 32'h20);
    stall = 1'b1;
    tick(); check("stall1_pc", current_pc, 32'h20);
    tick(); check("stall2_pc", current_pc, 32'h20);
    stall = 1'b0;
    tick(); check("post_stall_pc", current_pc, 32'h21);

    // 3. Halt masked by stall, then taken; restart
    branch_taken = 1'b1; branch_target = 32'h7; tick(); branch_taken = 1'b0;
    check("pc7", current_pc, 32'h7);
    halt = 1'b1; stall = 1'b1; tick();
    check_status("halt_stalled", 32'h7, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; tick(); halt = 1'b0;
    check_status("halted", 32'h7, 1'b0, 1'b1, 1'b0);
    tick();
    check_status("halted_hold", 32'h7, 1'b0, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check_status("restart", 32'h0, 1'b1, 1'b0, 1'b0);

    // 4. Fault on increment past the last word, and on an out-of-range branch
    branch_taken = 1'b1; branch_target = 32'hFFF; tick(); branch_taken = 1'b0;
    check_status("pc_fff", 32'hFFF, 1'b1, 1'b0, 1'b0);
    tick();
    check_status("fault_inc", 32'hFFF, 1'b0, 1'b0, 1'b1);
    tick();
    check_status("fault_hold", 32'hFFF, 1'b0, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_status("fault_restart", 32'h0, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h1000; tick(); branch_taken = 1'b0;
    check_status("fault_branch", 32'h0, 1'b0, 1'b0, 1'b1);

    // 5. Start ignored in RUN; reset mid-program
    start = 1'b1; tick();
    check("run_start0", current_pc, 32'h0);
    tick(); start = 1'b0;
    check("start_ignored", current_pc, 32'h1);
    tick(); tick(); tick(); tick();
    check("pc5", current_pc, 32'h5);
    reset = 1'b0; tick();
    check_status("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; tick();
    check_status("post_reset", 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    // 6. Counters: 10 retires, 3 stalls, halt (retired) -> 11 / 3
    start = 1'b1; tick(); start = 1'b0;
    check("cnt_clr_ret", retired_cnt, 32'd0);
    check("cnt_clr_stl", stall_cnt, 32'd0);
    repeat (10) tick();
    stall = 1'b1; repeat (3) tick(); stall = 1'b0;
    halt = 1'b1; tick(); halt = 1'b0;
    check("cnt_done", {31'd0, done}, 32'd1);
    check("cnt_retired", retired_cnt, 32'd11);
    check("cnt_stall", stall_cnt, 32'd3);
    start = 1'b1; tick(); start = 1'b0;
    check("cnt_restart_ret", retired_cnt, 32'd0);
    force dut.u_retired_cnt.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.u_retired_cnt.count_reg;
    tick();
    check("cnt_saturate", retired_cnt, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
